// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from a registered-output synchronous FIFO
// and shifts them onto tx LSB-first, one frame per popped byte.
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 434,
   parameter int WIDTH        = 8,
   parameter int CNT_BITS     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy
);

   localparam int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_BITS-1:0] BAUD_LAST = CNT_BITS'(CLKS_PER_BIT - 1);
   localparam logic [IDX_BITS-1:0] IDX_LAST  = IDX_BITS'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t               state_reg, state_next;
   logic [CNT_BITS-1:0]  baud_cnt_reg, baud_cnt_next;
   logic [IDX_BITS-1:0]  bit_idx_reg, bit_idx_next;
   logic [WIDTH-1:0]     shift_reg, shift_next;
   logic                 tx_reg, tx_next;
   logic                 baud_tc;

   assign baud_tc = (baud_cnt_reg == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      fifo_rd_en    = 1'b0;

      case (state_reg)
         IDLE: begin
            tx_next       = 1'b1;
            baud_cnt_next = '0;
            if (tx_en && !fifo_empty) begin
               fifo_rd_en = !rst;
               state_next = LATCH;
            end
         end

         // FIFO read data is registered, so the popped byte only appears now.
         LATCH: begin
            shift_next    = fifo_dout;
            tx_next       = 1'b0;
            baud_cnt_next = '0;
            state_next    = START;
         end

         START: begin
            if (baud_tc) begin
               baud_cnt_next = '0;
               tx_next       = shift_reg[0];
               bit_idx_next  = '0;
               state_next    = DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         DATA: begin
            if (baud_tc) begin
               baud_cnt_next = '0;
               if (bit_idx_reg != IDX_LAST) begin
                  shift_next   = {1'b0, shift_reg[WIDTH-1:1]};
                  tx_next      = shift_reg[1];
                  bit_idx_next = bit_idx_reg + 1'b1;
               end else begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (baud_tc) begin
               baud_cnt_next = '0;
               state_next    = IDLE;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next    = IDLE;
            baud_cnt_next = '0;
            tx_next       = 1'b1;
         end
      endcase
   end

   assign tx   = tx_reg;
   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three instances (4, 2 and 434 clocks per bit) fed by a
// FIFO model; a negedge monitor decodes frames against a byte scoreboard.
module tb_uart_tx_drain;

   logic       clk;
   logic       rst;
   logic [2:0] tx_en;
   logic [2:0] fifo_empty;
   logic [2:0] rd_en;
   logic [2:0] tx;
   logic [2:0] busy;
   logic [7:0] dout [3];

   logic [7:0] fmem [3][16];
   int         wp [3];
   int         rp [3];
   int         pops [3];

   logic [7:0] exp_q [$];

   int         checks;
   int         errors;
   int         cyc;
   int         frames_done;
   bit         in_fr [3];
   bit         prev_tx [3];
   int         k_m [3];
   logic [7:0] cur [3];
   bit         bad [3];
   int         last_rd [3];
   int         fall_t [3];
   int         prev_fall_t [3];

   function automatic int cpb_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 2 : 434;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         assign fifo_empty[gi] = (wp[gi] == rp[gi]);
         uart_tx_drain #(
            .CLKS_PER_BIT((gi == 0) ? 4 : (gi == 1) ? 2 : 434),
            .WIDTH       (8),
            .CNT_BITS    (9)
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_en     (tx_en[gi]),
            .fifo_empty(fifo_empty[gi]),
            .fifo_dout (dout[gi]),
            .fifo_rd_en(rd_en[gi]),
            .tx        (tx[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

   // FIFO model with registered read data
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rd_en[i]) begin
            dout[i] <= fmem[i][rp[i] % 16];
            rp[i]   <= rp[i] + 1;
            pops[i] <= pops[i] + 1;
         end
      end
   end

   // Monitor: expected line level is derived from the byte and the bit period only
   always @(negedge clk) begin
      int   b;
      logic e;
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            in_fr[i]   = 1'b0;
            prev_tx[i] = 1'b1;
         end else begin
            if (rd_en[i]) begin
               checks++;
               if (fifo_empty[i]) begin
                  errors++;
                  $display("FAIL pop_when_empty inst%0d: rd_en=1 while fifo_empty=1, required no pop", i);
               end
               last_rd[i] = cyc;
            end
            if (!in_fr[i] && prev_tx[i] && !tx[i]) begin
               in_fr[i]       = 1'b1;
               k_m[i]         = 0;
               bad[i]         = 1'b0;
               prev_fall_t[i] = fall_t[i];
               fall_t[i]      = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  cur[i] = 8'h00;
                  $display("FAIL unexpected_frame inst%0d: frame started with empty scoreboard", i);
               end else begin
                  cur[i] = exp_q.pop_front();
               end
               checks++;
               if (cyc - last_rd[i] != 2) begin
                  errors++;
                  $display("FAIL latency inst%0d: tx fell %0d cycles after rd_en, required 2", i, cyc - last_rd[i]);
               end
            end
            if (in_fr[i]) begin
               if (k_m[i] < 10 * cpb_of(i)) begin
                  b = k_m[i] / cpb_of(i);
                  if (b == 0)      e = 1'b0;
                  else if (b == 9) e = 1'b1;
                  else             e = cur[i][b-1];
                  if (tx[i] !== e || busy[i] !== 1'b1) begin
                     if (!bad[i])
                        $display("FAIL frame_wave inst%0d byte %02h: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                                 i, cur[i], k_m[i], tx[i], busy[i], e);
                     bad[i] = 1'b1;
                  end
                  k_m[i]++;
               end else begin
                  checks++;
                  if (bad[i]) errors++;
                  checks++;
                  if (tx[i] !== 1'b1 || busy[i] !== 1'b0) begin
                     errors++;
                     $display("FAIL frame_end inst%0d: tx=%b busy=%b after frame, required tx=1 busy=0", i, tx[i], busy[i]);
                  end
                  in_fr[i] = 1'b0;
                  frames_done++;
                  $display("frame inst%0d byte %02h done at cycle %0d", i, cur[i], cyc);
               end
            end
            prev_tx[i] = tx[i];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int i, input logic [7:0] v);
      fmem[i][wp[i] % 16] = v;
      wp[i] = wp[i] + 1;
      exp_q.push_back(v);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t = 0;
      while (frames_done < n && t < budget) begin
         @(posedge clk);
         t++;
      end
      #2;
      checks++;
      if (frames_done < n) begin
         errors++;
         $display("FAIL frame_timeout: frames_done=%0d, required %0d", frames_done, n);
      end
   endtask

   task automatic wait_k(input int i, input int kk, input int budget);
      int t = 0;
      while (!(in_fr[i] && k_m[i] >= kk) && t < budget) begin
         @(posedge clk);
         t++;
      end
      checks++;
      if (!(in_fr[i] && k_m[i] >= kk)) begin
         errors++;
         $display("FAIL frame_progress_timeout inst%0d: k=%0d, required %0d", i, k_m[i], kk);
      end
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   initial begin
      int bad_cnt;
      checks = 0; errors = 0; cyc = 0; frames_done = 0;
      for (int i = 0; i < 3; i++) begin
         wp[i] = 0; in_fr[i] = 1'b0; prev_tx[i] = 1'b1; k_m[i] = 0;
         last_rd[i] = 0; fall_t[i] = 0; prev_fall_t[i] = 0;
      end
      rst   = 1'b1;
      tx_en = 3'b111;

      // reset with empty FIFOs and enable high
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check("reset_outputs", int'({tx, busy, rd_en}), int'({3'b111, 3'b000, 3'b000}));
      end
      tick();
      rst = 1'b0;
      repeat (5) tick();
      check("idle_no_pop_when_empty", pops[0] + pops[1] + pops[2], 0);
      check("idle_tx_high", int'(tx), 7);
      tx_en = 3'b000;

      // single byte
      push(0, 8'hA5);
      tx_en[0] = 1'b1;
      wait_frames(1, 200);
      tx_en[0] = 1'b0;
      check("single_pops", pops[0], 1);
      $display("txn single A5: pops=%0d", pops[0]);

      // back-to-back
      push(0, 8'h00);
      push(0, 8'hFF);
      tx_en[0] = 1'b1;
      wait_frames(3, 300);
      tx_en[0] = 1'b0;
      check("b2b_period", fall_t[0] - prev_fall_t[0], 42);
      check("b2b_pops", pops[0], 3);
      check("b2b_fifo_empty", int'(fifo_empty[0]), 1);
      $display("txn b2b 00/FF: period=%0d pops=%0d", fall_t[0] - prev_fall_t[0], pops[0]);

      // tx_en gating
      push(0, 8'h3C);
      bad_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad_cnt++;
      end
      check("gate_idle_bad_cycles", bad_cnt, 0);
      check("gate_no_pop", pops[0], 3);
      tx_en[0] = 1'b1;
      wait_k(0, 14, 100);
      tx_en[0] = 1'b0;
      push(0, 8'h99);
      wait_frames(4, 200);
      repeat (20) tick();
      check("gate_no_second_pop", pops[0], 4);
      check("gate_fifo_still_full", int'(fifo_empty[0]), 0);
      tx_en[0] = 1'b1;
      wait_frames(5, 200);
      tx_en[0] = 1'b0;
      $display("txn gate 3C/99: pops=%0d", pops[0]);

      // asynchronous reset during data bit 3
      push(0, 8'h55);
      tx_en[0] = 1'b1;
      wait_k(0, 17, 100);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tx_busy", int'({tx[0], busy[0]}), 2);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_pops", pops[0], 6);
      push(0, 8'h81);
      wait_frames(6, 200);
      tx_en[0] = 1'b0;
      check("post_rst_frame_pops", pops[0], 7);
      $display("txn reset 55 then 81: pops=%0d", pops[0]);

      // baud extremes
      push(1, 8'h01);
      tx_en[1] = 1'b1;
      wait_frames(7, 100);
      tx_en[1] = 1'b0;
      check("cpb2_pops", pops[1], 1);
      $display("txn cpb2 01: pops=%0d", pops[1]);

      push(2, 8'h7E);
      tx_en[2] = 1'b1;
      wait_frames(8, 5000);
      tx_en[2] = 1'b0;
      check("cpb434_pops", pops[2], 1);
      $display("txn cpb434 7E: pops=%0d", pops[2]);

      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
